// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline and hazard_ctrl: ID/EX and IF/ID hazard inputs,
// stall/flush/bubble/hold controls and the stall statistics counter.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_RT_i;
  logic             IDEX_mul_i;
  logic [4:0]       IFID_RS_i;
  logic [4:0]       IFID_RT_i;
  logic             Branch_taken_i;
  logic             PC_write_o;
  logic             IFID_write_o;
  logic             IFID_flush_o;
  logic             IDEX_bubble_o;
  logic             IDEX_hold_o;
  logic             mul_busy_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output IDEX_MemRead_i, IDEX_RT_i, IDEX_mul_i, IFID_RS_i, IFID_RT_i, Branch_taken_i,
    input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, IDEX_hold_o,
           mul_busy_o, stall_cnt_o
  );

  modport slave (
    input  IDEX_MemRead_i, IDEX_RT_i, IDEX_mul_i, IFID_RS_i, IFID_RT_i, Branch_taken_i,
    output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o, IDEX_hold_o,
           mul_busy_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS core: multiply occupancy, load-use, branch flush.
// Optional saturating stall counter enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] MCNT_INIT = 4'(MUL_LAT - 2);

  state_t     state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic       mul_stall_s;
  logic       load_use_s;
  logic       pc_write_s;
  logic       ifid_write_s;
  logic       ifid_flush_s;
  logic       idex_bubble_s;
  logic       idex_hold_s;

  // State and multiply countdown registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      mcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Next state; the release cycle (BUSY, mcnt==0) does not stall and ignores IDEX_mul_i.
  always_comb begin
    state_d     = state_q;
    mcnt_d      = mcnt_q;
    mul_stall_s = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.IDEX_mul_i) begin
          mul_stall_s = 1'b1;
          state_d     = BUSY;
          mcnt_d      = MCNT_INIT;
        end else begin
          state_d = RUN;
        end
      end
      BUSY: begin
        if (mcnt_q != 4'd0) begin
          mul_stall_s = 1'b1;
          mcnt_d      = mcnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        mcnt_d  = 4'd0;
      end
    endcase
  end

  assign load_use_s = bus.IDEX_MemRead_i && (bus.IDEX_RT_i != 5'd0) &&
                      ((bus.IDEX_RT_i == bus.IFID_RS_i) || (bus.IDEX_RT_i == bus.IFID_RT_i));

  // Output priority: reset, then multiply stall, then load-use bubble, then branch flush.
  always_comb begin
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    idex_hold_s   = 1'b0;
    if (rst_i) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
    end else if (mul_stall_s) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      idex_hold_s  = 1'b1;
    end else if (load_use_s) begin
      pc_write_s    = 1'b0;
      ifid_write_s  = 1'b0;
      idex_bubble_s = 1'b1;
    end else begin
      ifid_flush_s = bus.Branch_taken_i;
    end
  end

  assign bus.PC_write_o    = pc_write_s;
  assign bus.IFID_write_o  = ifid_write_s;
  assign bus.IFID_flush_o  = ifid_flush_s;
  assign bus.IDEX_bubble_o = idex_bubble_s;
  assign bus.IDEX_hold_o   = idex_hold_s;
  assign bus.mul_busy_o    = (state_q == BUSY);

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles in which the PC was frozen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else if (!pc_write_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: occupancy-based reference model checked every negedge,
// plus hand-computed literal expectations along the stimulus sequence.
module tb_hazard_ctrl;
  localparam int CNT_W   = 2;
  localparam int MUL_LAT = 4;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  bit   checking = 1'b0;

  // Reference state: remaining EX occupancy cycles after the current one, and stall count.
  int   occ_left = 0;
  int   exp_cnt  = 0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [5:0] act_vec();
    return {bus.PC_write_o, bus.IFID_write_o, bus.IFID_flush_o,
            bus.IDEX_bubble_o, bus.IDEX_hold_o, bus.mul_busy_o};
  endfunction

  function automatic bit model_mul_stall();
    if (occ_left == 0) return bus.IDEX_mul_i;
    return occ_left > 1;
  endfunction

  function automatic bit model_load_use();
    return bus.IDEX_MemRead_i && bus.IDEX_RT_i != 5'd0 &&
           (bus.IDEX_RT_i == bus.IFID_RS_i || bus.IDEX_RT_i == bus.IFID_RT_i);
  endfunction

  function automatic logic [5:0] model_vec();
    bit ms, lu;
    if (rst) return 6'b000000;
    ms = model_mul_stall();
    lu = model_load_use();
    return {!(ms || lu), !(ms || lu), !ms && !lu && bus.Branch_taken_i,
            !ms && lu, ms, occ_left != 0};
  endfunction

  // Reference model update at each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_left <= 0;
      exp_cnt  <= 0;
    end else begin
      if (STATS && (model_mul_stall() || model_load_use()) && exp_cnt < (1 << CNT_W) - 1)
        exp_cnt <= exp_cnt + 1;
      if (occ_left == 0 && bus.IDEX_mul_i) occ_left <= MUL_LAT - 1;
      else if (occ_left > 0)               occ_left <= occ_left - 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("cycle_outputs", {26'd0, act_vec()}, {26'd0, model_vec()});
      check("cycle_stall_cnt", {30'd0, bus.stall_cnt_o}, exp_cnt);
    end
  end

  task automatic drive(input bit mr, input int rt, input int rs, input int ift,
                       input bit mul, input bit br);
    bus.IDEX_MemRead_i = mr;
    bus.IDEX_RT_i      = 5'(rt);
    bus.IFID_RS_i      = 5'(rs);
    bus.IFID_RT_i      = 5'(ift);
    bus.IDEX_mul_i     = mul;
    bus.Branch_taken_i = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector order: {PC_write, IFID_write, IFID_flush, IDEX_bubble, IDEX_hold, mul_busy}.
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    check("reset_outputs", {26'd0, act_vec()}, 32'h00);
    check("reset_cnt", {30'd0, bus.stall_cnt_o}, 32'd0);
    checking = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("idle_defaults", {26'd0, act_vec()}, 32'h30);

    tick(); drive(1, 8, 8, 3, 0, 0);
    check("load_use_rs", {26'd0, act_vec()}, 32'h04);
    tick(); drive(0, 8, 8, 3, 0, 0);
    check("load_use_cleared", {26'd0, act_vec()}, 32'h30);
    tick(); drive(1, 0, 0, 0, 0, 0);
    check("reg0_no_stall", {26'd0, act_vec()}, 32'h30);
    tick(); drive(1, 9, 8, 10, 0, 0);
    check("mismatch_no_stall", {26'd0, act_vec()}, 32'h30);
    tick(); drive(1, 10, 8, 10, 0, 0);
    check("load_use_rt", {26'd0, act_vec()}, 32'h04);

    tick(); drive(0, 0, 0, 0, 1, 0);
    check("mul_T", {26'd0, act_vec()}, 32'h02);
    tick(); drive(1, 8, 8, 8, 1, 1);
    check("mul_T1_priority", {26'd0, act_vec()}, 32'h03);
    tick(); drive(0, 0, 0, 0, 1, 0);
    check("mul_T2", {26'd0, act_vec()}, 32'h03);
    tick(); drive(0, 0, 0, 0, 1, 0);
    check("mul_release_T3", {26'd0, act_vec()}, 32'h31);
    tick(); drive(0, 0, 0, 0, 0, 0);
    check("mul_run_T4", {26'd0, act_vec()}, 32'h30);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("branch_flush", {26'd0, act_vec()}, 32'h38);

    tick(); drive(0, 0, 0, 0, 1, 0);
    check("mul2_T", {26'd0, act_vec()}, 32'h02);
    tick();
    check("mul2_T1", {26'd0, act_vec()}, 32'h03);
    #1 rst = 1'b1;
    #1;
    check("async_reset_outputs", {26'd0, act_vec()}, 32'h00);
    check("async_reset_cnt", {30'd0, bus.stall_cnt_o}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_reset_run", {26'd0, act_vec()}, 32'h30);
    check("post_reset_cnt", {30'd0, bus.stall_cnt_o}, 32'd0);

    drive(1, 8, 8, 0, 0, 0);
    tick(); tick();
    check("stats_after_2", {30'd0, bus.stall_cnt_o}, STATS ? 32'd2 : 32'd0);
    tick(); tick(); tick();
    check("stats_saturated", {30'd0, bus.stall_cnt_o}, STATS ? 32'd3 : 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
